pipe_addsub: RTL and testbench

Parametrised, pipelined integer add/subtract unit for the SimpleRisc ALU. It replaces the single-cycle 32-bit ripple-borrow subtractor. The carry/borrow chain is split into CHUNK-bit slices, with one register stage per slice, and the unit adds an add/sub mode, a valid/ready handshake with backpressure, and condition flags. The execute stage issues one operation per cycle; results leave in order after a fixed latency.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_slice.sv | 17 +
 rtl/pipe_addsub.sv | 158 +++++++++++++++
 tb/tb_pipe_addsub.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit:
// op encoding and the condition-flag bundle.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// One CHUNK-bit slice of the carry chain.
// Purely combinational; the top level registers its outputs.
module addsub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             zero
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign zero = (sum == '0);

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit, one register stage per CHUNK-bit slice.
// Global-advance flow control; results leave in order after STAGES edges.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int L      = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipe_addsub: WIDTH must be a multiple of CHUNK");
    end

    logic             adv;

    logic             v_q  [STAGES];
    logic             c_q  [STAGES];
    logic             z_q  [STAGES];
    logic             op_q [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] r_q  [STAGES];
    flags_t           flg_q;

    logic             v_s  [STAGES];
    logic             c_s  [STAGES];
    logic             z_s  [STAGES];
    logic             op_s [STAGES];
    logic [WIDTH-1:0] a_s  [STAGES];
    logic [WIDTH-1:0] b_s  [STAGES];
    logic [WIDTH-1:0] r_s  [STAGES];
    logic [WIDTH-1:0] r_n  [STAGES];
    flags_t           flg_n;

    logic [WIDTH-1:0]  sl_a;
    logic [WIDTH-1:0]  sl_b;
    logic [WIDTH-1:0]  sl_sum;
    logic [STAGES-1:0] sl_cin;
    logic [STAGES-1:0] sl_cout;
    logic [STAGES-1:0] sl_zero;

    // The last stage's carry/operand registers feed nothing downstream.
    logic unused_tail;
    assign unused_tail = c_q[L] ^ z_q[L] ^ op_q[L] ^ (^a_q[L]) ^ (^b_q[L]);

    assign adv       = !v_q[L] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[L];
    assign out_res   = r_q[L];
    assign out_cout  = flg_q.cout;
    assign out_ovf   = flg_q.ovf;
    assign out_zero  = flg_q.zero;
    assign out_neg   = flg_q.neg;

    // Stage inputs: stage 0 maps SUB to a + ~b + ~cin, later stages read k-1.
    always_comb begin
        v_s[0]  = in_valid;
        op_s[0] = in_op;
        c_s[0]  = (in_op == OP_SUB) ? ~in_cin : in_cin;
        z_s[0]  = 1'b1;
        a_s[0]  = in_a;
        b_s[0]  = (in_op == OP_SUB) ? ~in_b : in_b;
        r_s[0]  = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_s[k]  = v_q[k-1];
            op_s[k] = op_q[k-1];
            c_s[k]  = c_q[k-1];
            z_s[k]  = z_q[k-1];
            a_s[k]  = a_q[k-1];
            b_s[k]  = b_q[k-1];
            r_s[k]  = r_q[k-1];
        end
        sl_a   = '0;
        sl_b   = '0;
        sl_cin = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl_a[k*CHUNK +: CHUNK] = a_s[k][CHUNK-1:0];
            sl_b[k*CHUNK +: CHUNK] = b_s[k][CHUNK-1:0];
            sl_cin[k]              = c_s[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (sl_a[k*CHUNK +: CHUNK]),
            .b    (sl_b[k*CHUNK +: CHUNK]),
            .cin  (sl_cin[k]),
            .sum  (sl_sum[k*CHUNK +: CHUNK]),
            .cout (sl_cout[k]),
            .zero (sl_zero[k])
        );
    end

    // New slice enters at the top; finished slices shift down one chunk.
    // Flags are derived from the completed last-stage result.
    always_comb begin
        logic [WIDTH+CHUNK-1:0] cat;
        cat = '0;
        for (int k = 0; k < STAGES; k++) begin
            cat    = {sl_sum[k*CHUNK +: CHUNK], r_s[k]};
            r_n[k] = cat[WIDTH+CHUNK-1:CHUNK];
        end
        flg_n.cout = (op_s[L] == OP_SUB) ? ~sl_cout[L] : sl_cout[L];
        flg_n.ovf  = (a_s[L][CHUNK-1] == b_s[L][CHUNK-1]) &&
                     (r_n[L][WIDTH-1] != a_s[L][CHUNK-1]);
        flg_n.zero = z_s[L] && sl_zero[L];
        flg_n.neg  = r_n[L][WIDTH-1];
    end

    // Whole pipe shifts together on advance, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                c_q[k]  <= 1'b0;
                z_q[k]  <= 1'b0;
                op_q[k] <= 1'b0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                r_q[k]  <= '0;
            end
            flg_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= v_s[k];
                c_q[k]  <= sl_cout[k];
                z_q[k]  <= z_s[k] && sl_zero[k];
                op_q[k] <= op_s[k];
                a_q[k]  <= a_s[k] >> CHUNK;
                b_q[k]  <= b_s[k] >> CHUNK;
                r_q[k]  <= r_n[k];
            end
            flg_q <= flg_n;
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and short random checks for pipe_addsub,
// plus latency checks for the 1-stage and 8-stage builds.
module tb_pipe_addsub;
    import addsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_op;
    logic        in_cin;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;
    logic        rdy1 = 1'b1;

    logic        in_ready, out_valid, out_cout, out_ovf, out_zero, out_neg;
    logic [31:0] out_res;
    logic        r1_in_ready, r1_valid, r1_cout, r1_ovf, r1_zero, r1_neg;
    logic [31:0] r1_res;
    logic        r8_in_ready, r8_valid, r8_cout, r8_ovf, r8_zero, r8_neg;
    logic [31:0] r8_res;

    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];
    logic [35:0] prev;
    logic [35:0] e;
    logic        hold;
    logic        have;
    int          first, cur, maxrun, sent, recv;

    always #5 clk = ~clk;

    pipe_addsub u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
        .out_neg(out_neg)
    );

    pipe_addsub #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(r1_valid), .out_ready(rdy1), .out_res(r1_res),
        .out_cout(r1_cout), .out_ovf(r1_ovf), .out_zero(r1_zero),
        .out_neg(r1_neg)
    );

    pipe_addsub #(.WIDTH(32), .CHUNK(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(r8_valid), .out_ready(rdy1), .out_res(r8_res),
        .out_cout(r8_cout), .out_ovf(r8_ovf), .out_zero(r8_zero),
        .out_neg(r8_neg)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] model(input logic op, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov;
        if (op == OP_ADD) begin
            s  = {1'b0, a} + {1'b0, b} + {32'b0, c};
            r  = s[31:0];
            ov = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            s  = {1'b0, a} - {1'b0, b} - {32'b0, c};
            r  = s[31:0];
            ov = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {s[32], ov, (r == 32'd0), r[31], r};
    endfunction

    function automatic logic [35:0] obs();
        return {out_cout, out_ovf, out_zero, out_neg, out_res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_op(input string tag, input logic op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [35:0] exp);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk({tag, "_early"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, obs(), exp);
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_ADD;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_out", obs(), 36'h0);
        chk("rst_in_ready", in_ready, 1);
        step();
        step();
        #2 rst_n = 1'b1;
        step();

        one_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 36'hA_0000_0000);
        one_op("sub_under", OP_SUB, 32'h0, 32'h1, 1'b0, 36'h9_FFFF_FFFF);
        one_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 1'b0, 36'h4_7FFF_FFFF);
        one_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 36'h5_8000_0000);
        one_op("sub_bin", OP_SUB, 32'h5, 32'h3, 1'b1, 36'h0_0000_0001);
        one_op("add_cin", OP_ADD, 32'h0000_00FF, 32'h0000_0100, 1'b1, 36'h0_0000_0200);

        first  = -1;
        cur    = 0;
        maxrun = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                in_valid = 1'b1;
                in_op    = 1'($urandom_range(0, 1));
                in_a     = $urandom;
                in_b     = $urandom;
                in_cin   = 1'($urandom_range(0, 1));
                exp_q.push_back(model(in_op, in_a, in_b, in_cin));
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (out_valid) begin
                if (first < 0) first = c;
                cur++;
                if (cur > maxrun) maxrun = cur;
                chk("stream_have_exp", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stream_res", obs(), e);
                end
            end else begin
                cur = 0;
            end
        end
        chk("stream_fill", first, 3);
        chk("stream_run", maxrun, 16);
        chk("stream_left", exp_q.size(), 0);

        sent = 0;
        recv = 0;
        hold = 1'b0;
        have = 1'b0;
        prev = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 6 && c < 12);
            if (!have && sent < 10) begin
                in_op  = 1'($urandom_range(0, 1));
                in_a   = $urandom;
                in_b   = $urandom;
                in_cin = 1'($urandom_range(0, 1));
                have   = 1'b1;
            end
            in_valid = have;
            #1;
            if (hold) begin
                chk("stall_stable", obs(), prev);
                chk("stall_valid", out_valid, 1);
            end
            if (c == 11) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("stall_have_exp", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stall_res", obs(), e);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_op, in_a, in_b, in_cin));
                sent++;
                have = 1'b0;
            end
            hold = out_valid && !out_ready;
            prev = obs();
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_sent", sent, 10);
        chk("stall_recv", recv, 10);
        chk("stall_left", exp_q.size(), 0);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = OP_ADD;
            in_a     = 32'(10 + i);
            in_b     = 32'(20 + i);
            in_cin   = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_res", out_res, 32'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out", obs(), 36'h0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_r1", r1_valid, 0);
        chk("mid_rst_r8", r8_valid, 0);
        step();
        step();
        chk("in_rst_valid", out_valid, 0);
        #2 rst_n = 1'b1;
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 32'd2;
        in_b     = 32'd2;
        in_cin   = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            in_valid = 1'b0;
            chk("lat4_valid", out_valid, (n == 4));
            chk("lat1_valid", r1_valid, (n == 1));
            chk("lat8_valid", r8_valid, (n == 8));
            if (n == 4) chk("lat4_res", out_res, 32'd4);
            if (n == 1) chk("lat1_res", r1_res, 32'd4);
            if (n == 8) chk("lat8_res", r8_res, 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
